// File: rtl/vdma_frame_pkg.sv
// Shared definitions for the VDMA frame-buffer rotation controllers.
//   A_FRAME_ADDR_STEP_LINE / _ONCE : DDR distance between 1080p frame buffers
//   buf_idx_t                      : 2-bit frame-buffer index
//   next_wr_idx()                  : next write buffer, skipping the read buffer
package vdma_frame_pkg;

    localparam int unsigned A_FRAME_ADDR_STEP_LINE = 256*8*1080;
    localparam int unsigned A_FRAME_ADDR_STEP_ONCE = 180*8*1080;

    typedef logic [1:0] buf_idx_t;

    // Step to the next buffer. If that buffer is being read, step one more.
    // With at least 3 buffers the result differs from both rd and wr.
    function automatic buf_idx_t next_wr_idx(buf_idx_t wr, buf_idx_t rd, int unsigned num_buf);
        int unsigned n;
        n = (32'(wr) + 32'd1) % num_buf;
        if (n == 32'(rd))
            n = (32'(wr) + 32'd2) % num_buf;
        return buf_idx_t'(n);
    endfunction

endpackage

// File: rtl/vsync_edge_sync.sv
// Synchronises an asynchronous vsync level into the clk_i domain.
// It emits a one-cycle pulse on each rising edge.
//   clk_i   : system clock
//   rst_i   : asynchronous active-high reset; all flops clear to 0
//   async_i : vsync level from the pixel-clock domain
//   start_o : 1-cycle pulse, high in the cycle after the 2nd sampling edge
module vsync_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic start_o
);

    logic meta_q;
    logic sync_q;
    logic last_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            last_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            last_q <= sync_q;
        end
    end

    // Because the flops reset to 0, a vsync held high across reset release
    // still yields exactly one pulse.
    assign start_o = sync_q & ~last_q;

endmodule

// File: rtl/vdma_frame_buf_ctrl.sv
// Per-channel frame-buffer rotation controller.
// It rotates NUM_BUF (3..4) DDR frame buffers so that the reader always
// scans the most recently completed frame. The reader never scans the
// buffer that is currently being written.
//   axi_aclk, axi_reset    : clock, asynchronous active-high reset
//   enable                 : low freezes indices and suppresses status pulses
//   wr_vsync, rd_vsync     : asynchronous vsync levels of the writer and the reader
//   wr_baseaddr/rd_baseaddr: registered base addresses of the current buffers
//   wr_idx/rd_idx          : current buffer indices
//   frame_drop             : pulse, a completed frame was replaced before it was read
//   rd_repeat              : pulse, a read frame started with no new frame available
module vdma_frame_buf_ctrl
    import vdma_frame_pkg::*;
#(
    parameter int unsigned ASIZE      = 29,
    parameter int unsigned NUM_BUF    = 3,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned FRAME_STEP = A_FRAME_ADDR_STEP_LINE
) (
    input  logic             axi_aclk,
    input  logic             axi_reset,
    input  logic             enable,
    input  logic             wr_vsync,
    input  logic             rd_vsync,
    output logic [ASIZE-1:0] wr_baseaddr,
    output logic [ASIZE-1:0] rd_baseaddr,
    output logic [1:0]       wr_idx,
    output logic [1:0]       rd_idx,
    output logic             frame_drop,
    output logic             rd_repeat
);

    // Buffer base address. The result wraps modulo 2^ASIZE.
    function automatic logic [ASIZE-1:0] buf_addr(buf_idx_t idx);
        logic [63:0] a;
        a = 64'(BASE_ADDR) + 64'(idx) * 64'(FRAME_STEP);
        return a[ASIZE-1:0];
    endfunction

    logic wr_start;
    logic rd_start;

    vsync_edge_sync u_wr_sync (
        .clk_i   (axi_aclk),
        .rst_i   (axi_reset),
        .async_i (wr_vsync),
        .start_o (wr_start)
    );

    vsync_edge_sync u_rd_sync (
        .clk_i   (axi_aclk),
        .rst_i   (axi_reset),
        .async_i (rd_vsync),
        .start_o (rd_start)
    );

    buf_idx_t         wr_idx_q, wr_idx_d;
    buf_idx_t         rd_idx_q, rd_idx_d;
    buf_idx_t         done_idx_q, done_idx_d;
    logic             done_valid_q, done_valid_d;
    logic             drop_q, drop_d;
    logic             repeat_q, repeat_d;
    logic             consumed;
    logic [ASIZE-1:0] wr_addr_q;
    logic [ASIZE-1:0] rd_addr_q;

    // The read side is resolved first. A simultaneous write then sees the
    // new rd_idx, and it sees done_valid as it is after any consumption.
    always_comb begin
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        done_idx_d   = done_idx_q;
        done_valid_d = done_valid_q;
        drop_d       = 1'b0;
        repeat_d     = 1'b0;
        consumed     = 1'b0;
        if (enable) begin
            if (rd_start) begin
                if (done_valid_q) begin
                    rd_idx_d     = done_idx_q;
                    done_valid_d = 1'b0;
                    consumed     = 1'b1;
                end else begin
                    repeat_d = 1'b1;
                end
            end
            if (wr_start) begin
                drop_d       = done_valid_q & ~consumed;
                done_idx_d   = wr_idx_q;
                done_valid_d = 1'b1;
                wr_idx_d     = next_wr_idx(wr_idx_q, rd_idx_d, NUM_BUF);
            end
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            wr_idx_q     <= buf_idx_t'(0);
            rd_idx_q     <= buf_idx_t'(NUM_BUF - 1);
            done_idx_q   <= buf_idx_t'(0);
            done_valid_q <= 1'b0;
            drop_q       <= 1'b0;
            repeat_q     <= 1'b0;
            wr_addr_q    <= buf_addr(buf_idx_t'(0));
            rd_addr_q    <= buf_addr(buf_idx_t'(NUM_BUF - 1));
        end else begin
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            done_idx_q   <= done_idx_d;
            done_valid_q <= done_valid_d;
            drop_q       <= drop_d;
            repeat_q     <= repeat_d;
            // Addresses follow the index registers one cycle later.
            wr_addr_q    <= buf_addr(wr_idx_q);
            rd_addr_q    <= buf_addr(rd_idx_q);
        end
    end

    assign wr_idx      = wr_idx_q;
    assign rd_idx      = rd_idx_q;
    assign wr_baseaddr = wr_addr_q;
    assign rd_baseaddr = rd_addr_q;
    assign frame_drop  = drop_q;
    assign rd_repeat   = repeat_q;

endmodule

// File: tb/tb_vdma_frame_buf_ctrl.sv
module tb_vdma_frame_buf_ctrl;

    localparam longint STEP  = 2211840;
    localparam longint AMOD  = 64'd1 << 29;
    localparam longint BASE2 = AMOD - STEP;

    logic clk = 1'b0;
    logic rst, en, wv, rv;

    logic [28:0] wa0, ra0, wa1, ra1, wa2, ra2;
    logic [1:0]  wi0, ri0, wi1, ri1, wi2, ri2;
    logic        fd0, rr0, fd1, rr1, fd2, rr2;

    always #5 clk = ~clk;

    vdma_frame_buf_ctrl #(.ASIZE(29), .NUM_BUF(3), .BASE_ADDR(0), .FRAME_STEP(2211840)) dut0 (
        .axi_aclk(clk), .axi_reset(rst), .enable(en), .wr_vsync(wv), .rd_vsync(rv),
        .wr_baseaddr(wa0), .rd_baseaddr(ra0), .wr_idx(wi0), .rd_idx(ri0),
        .frame_drop(fd0), .rd_repeat(rr0));

    vdma_frame_buf_ctrl #(.ASIZE(29), .NUM_BUF(3), .BASE_ADDR(32'(BASE2)), .FRAME_STEP(2211840)) dut1 (
        .axi_aclk(clk), .axi_reset(rst), .enable(en), .wr_vsync(wv), .rd_vsync(rv),
        .wr_baseaddr(wa1), .rd_baseaddr(ra1), .wr_idx(wi1), .rd_idx(ri1),
        .frame_drop(fd1), .rd_repeat(rr1));

    vdma_frame_buf_ctrl #(.ASIZE(29), .NUM_BUF(4), .BASE_ADDR(0), .FRAME_STEP(2211840)) dut2 (
        .axi_aclk(clk), .axi_reset(rst), .enable(en), .wr_vsync(wv), .rd_vsync(rv),
        .wr_baseaddr(wa2), .rd_baseaddr(ra2), .wr_idx(wi2), .rd_idx(ri2),
        .frame_drop(fd2), .rd_repeat(rr2));

    int n_tests = 0;
    int n_fail  = 0;
    int drop_cnt, rep_cnt;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: behaviour per sampled edge, one entry per DUT.
    int     nb[3]   = '{3, 3, 4};
    longint base[3] = '{0, BASE2, 0};
    int     mw[3], mr[3], mdn[3], mwa[3], mra[3];
    bit     mdv[3], md[3], mp[3];
    bit     wp1, wp2, wp3, rp1, rp2, rp3;  // vsync samples of the last 3 edges

    function automatic longint exp_addr(int m, int idx);
        return (base[m] + longint'(idx) * STEP) % AMOD;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            mw[m] = 0; mr[m] = nb[m] - 1; mdn[m] = 0; mdv[m] = 0;
            mwa[m] = 0; mra[m] = nb[m] - 1; md[m] = 0; mp[m] = 0;
        end
        {wp1, wp2, wp3, rp1, rp2, rp3} = '0;
    endtask

    task automatic model_step();
        bit ws, rs;
        if (rst) begin
            model_reset();
            return;
        end
        // A start takes effect on the edge two samples after vsync was first seen high.
        ws = wp2 && !wp3;
        rs = rp2 && !rp3;
        for (int m = 0; m < 3; m++) begin
            mwa[m] = mw[m];
            mra[m] = mr[m];
            md[m] = 0;
            mp[m] = 0;
            if (en) begin
                if (rs) begin
                    if (mdv[m]) begin
                        mr[m] = mdn[m];
                        mdv[m] = 0;
                    end else begin
                        mp[m] = 1;
                    end
                end
                if (ws) begin
                    md[m] = mdv[m];
                    mdn[m] = mw[m];
                    mdv[m] = 1;
                    if ((mw[m] + 1) % nb[m] != mr[m]) mw[m] = (mw[m] + 1) % nb[m];
                    else                              mw[m] = (mw[m] + 2) % nb[m];
                end
            end
        end
        wp3 = wp2; wp2 = wp1; wp1 = wv;
        rp3 = rp2; rp2 = rp1; rp1 = rv;
    endtask

    task automatic check_model(input int m, input logic [1:0] wi, input logic [1:0] ri,
                               input logic [28:0] wa, input logic [28:0] ra,
                               input logic fd, input logic rr);
        string s;
        s = $sformatf("rand%0d", m);
        check({s, ".wr_idx"}, wi, mw[m]);
        check({s, ".rd_idx"}, ri, mr[m]);
        check({s, ".wr_baseaddr"}, wa, exp_addr(m, mwa[m]));
        check({s, ".rd_baseaddr"}, ra, exp_addr(m, mra[m]));
        check({s, ".frame_drop"}, fd, md[m]);
        check({s, ".rd_repeat"}, rr, mp[m]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (fd0) drop_cnt++;
        if (rr0) rep_cnt++;
    endtask

    typedef struct {
        bit w; bit r; bit e;
        int ewi; int eri; int edrop; int erep;
    } vec_t;

    vec_t tbl[8];

    initial begin
        // Rows continue from wr=1, rd=2, done=0 valid (left by the latency test).
        tbl[0] = '{w:0, r:1, e:1, ewi:1, eri:0, edrop:0, erep:0};
        tbl[1] = '{w:1, r:0, e:1, ewi:2, eri:0, edrop:0, erep:0};
        tbl[2] = '{w:1, r:0, e:1, ewi:1, eri:0, edrop:1, erep:0};
        tbl[3] = '{w:1, r:1, e:1, ewi:0, eri:2, edrop:0, erep:0};
        tbl[4] = '{w:0, r:1, e:1, ewi:0, eri:1, edrop:0, erep:0};
        tbl[5] = '{w:0, r:1, e:1, ewi:0, eri:1, edrop:0, erep:1};
        tbl[6] = '{w:1, r:0, e:0, ewi:0, eri:1, edrop:0, erep:0};
        tbl[7] = '{w:1, r:0, e:1, ewi:2, eri:1, edrop:0, erep:0};

        rst = 1'b1; en = 1'b1; wv = 1'b0; rv = 1'b0;
        model_reset();
        drop_cnt = 0; rep_cnt = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset values
        check("rst.wr_idx", wi0, 0);
        check("rst.rd_idx", ri0, 2);
        check("rst.wr_baseaddr", wa0, 0);
        check("rst.rd_baseaddr", ra0, 4423680);
        check("rst.frame_drop", fd0, 0);
        check("rst.rd_repeat", rr0, 0);
        check("rst.wrap_wr_baseaddr", wa1, BASE2);
        check("rst.wrap_rd_baseaddr", ra1, STEP);
        check("rst.nb4_rd_idx", ri2, 3);
        check("rst.nb4_rd_baseaddr", ra2, 3 * STEP);

        // Latency of the first write edge
        drop_cnt = 0; rep_cnt = 0;
        wv = 1'b1;
        tick();
        check("lat.e1.wr_idx", wi0, 0);
        tick();
        check("lat.e2.wr_idx", wi0, 0);
        tick();
        check("lat.e3.wr_idx", wi0, 1);
        check("lat.e3.wr_baseaddr", wa0, 0);
        tick();
        check("lat.e4.wr_baseaddr", wa0, STEP);
        check("lat.e4.wrap_wr_baseaddr", wa1, 0);
        wv = 1'b0;
        repeat (4) tick();
        check("lat.rd_idx", ri0, 2);
        check("lat.drop", drop_cnt, 0);

        // Table of vsync events
        for (int i = 0; i < 8; i++) begin
            drop_cnt = 0; rep_cnt = 0;
            wv = tbl[i].w; rv = tbl[i].r; en = tbl[i].e;
            repeat (4) tick();
            wv = 1'b0; rv = 1'b0;
            repeat (4) tick();
            en = 1'b1;
            tick();
            check($sformatf("vec%0d.wr_idx", i), wi0, tbl[i].ewi);
            check($sformatf("vec%0d.rd_idx", i), ri0, tbl[i].eri);
            check($sformatf("vec%0d.wr_baseaddr", i), wa0, tbl[i].ewi * STEP);
            check($sformatf("vec%0d.rd_baseaddr", i), ra0, tbl[i].eri * STEP);
            check($sformatf("vec%0d.frame_drop_cnt", i), drop_cnt, tbl[i].edrop);
            check($sformatf("vec%0d.rd_repeat_cnt", i), rep_cnt, tbl[i].erep);
        end

        // Asynchronous reset mid-frame, vsync kept high through release
        wv = 1'b1;
        tick();
        tick();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("arst.wr_idx", wi0, 0);
        check("arst.rd_idx", ri0, 2);
        check("arst.wr_baseaddr", wa0, 0);
        check("arst.rd_baseaddr", ra0, 4423680);
        check("arst.frame_drop", fd0, 0);
        check("arst.rd_repeat", rr0, 0);
        tick();
        tick();
        rst = 1'b0;
        drop_cnt = 0; rep_cnt = 0;
        repeat (10) tick();
        check("relhi.wr_idx", wi0, 1);
        check("relhi.nb4_wr_idx", wi2, 1);
        check("relhi.rd_idx", ri0, 2);
        check("relhi.drop", drop_cnt, 0);

        // Random vsync and enable traffic against the model
        wv = 1'b0; rv = 1'b0;
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        begin
            int wcnt, rcnt;
            wcnt = 0; rcnt = 0;
            for (int c = 0; c < 3000; c++) begin
                tick();
                check_model(0, wi0, ri0, wa0, ra0, fd0, rr0);
                check_model(1, wi1, ri1, wa1, ra1, fd1, rr1);
                check_model(2, wi2, ri2, wa2, ra2, fd2, rr2);
                wcnt++; rcnt++;
                if (wcnt >= 3 && $urandom_range(0, 2) == 0) begin wv = ~wv; wcnt = 0; end
                if (rcnt >= 3 && $urandom_range(0, 2) == 0) begin rv = ~rv; rcnt = 0; end
                en = ($urandom_range(0, 9) != 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vdma_frame_buf_ctrl.md
# vdma_frame_buf_ctrl

Per-channel frame-buffer rotation controller feeding `wr_baseaddr[n]` / `rd_baseaddr[n]` of `multiports_vdma_verb`, one instance per channel. Tracks write-side and read-side vertical syncs and rotates 3 or 4 DDR frame buffers so the read port always scans the most recently completed frame. The read port never scans a buffer that is being written.

## Interface
- `ASIZE`, 29, DDR app address width
- `NUM_BUF`, 3, number of frame buffers; legal 3..4
- `BASE_ADDR`, 0, address of buffer 0
- `FRAME_STEP`, 2211840 (256*8*1080, LINE mode 1080p), address distance between buffers
- `axi_aclk`  in  1  system clock
- `axi_reset`  in  1  asynchronous, active-high reset
- `enable`  in  1  rotation enable; low freezes indices
- `wr_vsync`  in  1  write-side vsync, level, asynchronous (pixel domain)
- `rd_vsync`  in  1  read-side vsync, level, asynchronous
- `wr_baseaddr`  out  ASIZE  base of buffer being written
- `rd_baseaddr`  out  ASIZE  base of buffer being read
- `wr_idx`  out  2  current write buffer index
- `rd_idx`  out  2  current read buffer index
- `frame_drop`  out  1  1-cycle pulse: completed frame overwritten before read consumed it
- `rd_repeat`  out  1  1-cycle pulse: read frame start with no new frame; buffer reused

## Operation
- Each vsync passes through a 2-flop synchronizer and a third flop. Rising-edge detect gives a 1-cycle start pulse (`wr_start`, `rd_start`).
- Internal state: `wr_idx`, `rd_idx`, `done_idx`, `done_valid`.
- Reset values:
  - `wr_idx=0`, `rd_idx=NUM_BUF-1`, `done_idx=0`, `done_valid=0`.
  - `wr_baseaddr=BASE_ADDR`, `rd_baseaddr=BASE_ADDR+(NUM_BUF-1)*FRAME_STEP`.
  - Pulses 0 and synchronizer flops 0.
- On `rd_start` (enable=1):
  - If `done_valid`: `rd_idx<=done_idx`, `done_valid<=0`.
  - Otherwise: hold `rd_idx` and pulse `rd_repeat`.
- On `wr_start` (enable=1):
  - Set `done_idx<=wr_idx` and `done_valid<=1`. If `done_valid` was already 1 and the read did not consume it in the same cycle, pulse `frame_drop`.
  - Next write index is `n=(wr_idx+1) mod NUM_BUF`. If `n` equals the effective `rd_idx`, use `n=(wr_idx+2) mod NUM_BUF` instead.
  - With NUM_BUF>=3 the result never equals `rd_idx` or the old `wr_idx`.
- Simultaneous `wr_start` and `rd_start`: the read is resolved first.
  - Read takes the old `done_idx`/`done_valid`.
  - Write then avoids the new `rd_idx` and sets `done` to the old `wr_idx`.
- Address computation: `addr = BASE_ADDR + idx*FRAME_STEP`, truncated to ASIZE bits (mod 2^ASIZE). Registered from the index registers.
- `enable=0`:
  - Start pulses are ignored; no index change and no status pulses.
  - Edge detectors keep running, so an edge during disable is lost, not deferred.
- A vsync that is high when reset is released produces a start pulse, because the synchronizer resets to 0.
- Asserting reset mid-frame returns all state to reset values asynchronously.

## Timing
- Latency: the first `axi_aclk` edge sampling `wr_vsync`=1 is edge 1.
  - Start pulse is high after edge 2.
  - Index updates at edge 3.
  - `wr_baseaddr` updates at edge 4.
  - The same latency applies to the read side.
- `frame_drop` and `rd_repeat` assert in the cycle after edge 3, i.e. they are registered together with the index update.
- Vsync high and low phases must each be >=3 `axi_aclk` cycles; shorter pulses may be missed.
- Addresses are stable between start events. The consumer samples them at its own frame start, which occurs later than edge 4.

## Structure
- Shared package `vdma_frame_pkg`:
  - `A_FRAME_ADDR_STEP_LINE` = 256*8*1080 and `A_FRAME_ADDR_STEP_ONCE` = 180*8*1080.
  - `buf_idx_t` (2-bit) and the `next_wr_idx` function.
- Sub-module `vsync_edge_sync`: 2-flop synchronizer, edge flop and rising-edge pulse, async active-high reset. Instantiated twice.

## Test plan
- Reset, NUM_BUF=3 -> `wr_baseaddr=0`, `rd_baseaddr=4423680`, `wr_idx=0`, `rd_idx=2`, no pulses.
- Sequence:
  - wr edge -> `wr_baseaddr=2211840` exactly 4 edges after vsync sampled high.
  - rd edge -> `rd_baseaddr=0`.
  - wr edge -> `wr_idx=2`.
  - wr edge -> `wr_idx` skips 0 (read) -> 1, `frame_drop`=1 for one cycle.
- rd edge with `done_valid=0` -> `rd_repeat` pulses once, `rd_baseaddr` unchanged.
- Same-cycle wr and rd edges from state wr=1, rd=0, done=2 valid -> rd=2, wr=0, done=1 valid, no pulses.
- enable=0 during a wr edge, then enable=1 -> indices unchanged, no pulse. BASE_ADDR=2^29-2211840 with idx 1 -> address wraps to 0.
- Reset asserted 2 cycles after a vsync edge -> all outputs return to reset values immediately. Vsync held high through reset release -> exactly one start pulse.
